// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM state encoding
//   ADDR_W        : instruction (word) address width
//   INSTR_W       : instruction width, two bytes
//   BYTE_W        : memory read width
//   MAX_WAIT_DEF  : default mem_ack timeout in cycles
//   WDT_W         : width of the timeout counter (covers MAX_WAIT up to 255)
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int ADDR_W       = 8;
    localparam int INSTR_W      = 16;
    localparam int BYTE_W       = 8;
    localparam int MAX_WAIT_DEF = 15;
    localparam int WDT_W        = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_LO = 3'd1,
        REQ_HI = 3'd2,
        HOLD   = 3'd3,
        ERROR  = 3'd4
    } fetch_state_t;

    // True in the states that drive a memory request.
    function automatic logic is_req_state(input fetch_state_t s);
        return (s == REQ_LO) || (s == REQ_HI);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bus bundle of the fetch unit: the byte-wide instruction memory port and the
// instruction hand-off to the decoder.
//   mem_req / mem_addr      : read request and byte address  (fetch -> memory)
//   mem_ack / mem_rdata     : read completion and data       (memory -> fetch)
//   instr_valid / data/addr : held instruction               (fetch -> decoder)
//   instr_ready             : decoder accepts                (decoder -> fetch)
// Modports: master = fetch unit side, slave = memory/decoder side.
// -----------------------------------------------------------------------------
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic                 mem_req;
    logic [ADDR_W:0]      mem_addr;
    logic                 mem_ack;
    logic [BYTE_W-1:0]    mem_rdata;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [INSTR_W-1:0]   instr_data;
    logic [ADDR_W-1:0]    instr_addr;

    modport master (
        output mem_req, mem_addr, instr_valid, instr_data, instr_addr,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr_data, instr_addr,
        output mem_ack, mem_rdata, instr_ready
    );

endinterface

// File: rtl/instr_fetch_wdt.sv
// -----------------------------------------------------------------------------
// fetch_wdt
// Wait counter guarding a memory request.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart counting from zero (takes priority over count)
//   count      : one more cycle spent waiting for mem_ack
//   limit      : number of wait cycles tolerated
//   expired    : counter has reached limit
// -----------------------------------------------------------------------------
module fetch_wdt
    import instr_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             count,
    input  logic [WDT_W-1:0] limit,
    output logic             expired
);

    logic [WDT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q >= limit);

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetches 16-bit instructions as two byte reads (low byte at {addr,0}, high
// byte at {addr,1}) and holds each one until the decoder accepts it.
//   clk, rst_n : clock, asynchronous active-low reset
//   pc_addr    : instruction address from the program counter
//   pc_en      : one-cycle pulse per accepted instruction (advances the PC)
//   flush      : drop the current/held instruction, refetch from pc_addr
//   fetch_err  : sticky flag, memory did not answer within MAX_WAIT cycles
//   bus        : memory request/response and decoder hand-off (master side)
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_en,
    input  logic              flush,
    output logic              fetch_err,
    instr_fetch_if.master     bus
);

    localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(MAX_WAIT);

    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [INSTR_W-1:0]  instr_data_q;
    logic [ADDR_W-1:0]   instr_addr_q;
    logic                discard_q;
    logic                fetch_err_q;

    logic                req;
    logic                byte_sel;
    logic                valid;
    logic                lo_ack;
    logic                hi_ack;
    logic                wdt_clear;
    logic                wdt_count;
    logic                wdt_expired;

    fetch_wdt u_wdt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wdt_clear),
        .count   (wdt_count),
        .limit   (WDT_LIMIT),
        .expired (wdt_expired)
    );

    // Next state and outputs. A request, once raised, is only ended by an
    // ack or the timeout; flush merely marks the result for discarding.
    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        byte_sel = 1'b0;
        valid    = 1'b0;
        pc_en    = 1'b0;
        lo_ack   = 1'b0;
        hi_ack   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!flush) begin
                    state_d = REQ_LO;
                end
            end

            REQ_LO: begin
                req = !wdt_expired;
                if (req && bus.mem_ack) begin
                    lo_ack  = 1'b1;
                    state_d = REQ_HI;
                end else if (wdt_expired) begin
                    state_d = ERROR;
                end
            end

            REQ_HI: begin
                req      = !wdt_expired;
                byte_sel = 1'b1;
                if (req && bus.mem_ack) begin
                    hi_ack  = 1'b1;
                    // A flush arriving together with the final ack also counts.
                    state_d = (discard_q || flush) ? IDLE : HOLD;
                end else if (wdt_expired) begin
                    state_d = ERROR;
                end
            end

            HOLD: begin
                // Flush beats a simultaneous instr_ready.
                valid = !flush;
                pc_en = !flush && bus.instr_ready;
                if (flush || bus.instr_ready) begin
                    state_d = IDLE;
                end
            end

            ERROR: begin
                state_d = ERROR;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Wait counter restarts on every entry into a request state and only
    // counts cycles that actually have an outstanding request.
    assign wdt_clear = (state_d != state_q) && is_req_state(state_d);
    assign wdt_count = req && !bus.mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if ((state_q == IDLE) && !flush) begin
            addr_q <= pc_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_data_q <= '0;
            instr_addr_q <= '0;
        end else begin
            if (lo_ack) begin
                instr_data_q[BYTE_W-1:0] <= bus.mem_rdata;
            end
            if (hi_ack) begin
                instr_data_q[INSTR_W-1:BYTE_W] <= bus.mem_rdata;
                instr_addr_q                   <= addr_q;
            end
        end
    end

    // discard_q only lives across a transfer; any exit from the request
    // states (completion or timeout) leaves it cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            discard_q <= 1'b0;
        end else if (is_req_state(state_q) && !hi_ack) begin
            discard_q <= discard_q || flush;
        end else begin
            discard_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_err_q <= 1'b0;
        end else if ((state_q != ERROR) && (state_d == ERROR)) begin
            fetch_err_q <= 1'b1;
        end
    end

    assign bus.mem_req     = req;
    assign bus.mem_addr    = {addr_q, byte_sel};
    assign bus.instr_valid = valid;
    assign bus.instr_data  = instr_data_q;
    assign bus.instr_addr  = instr_addr_q;
    assign fetch_err       = fetch_err_q;

endmodule
